dot_product_mc: RTL and testbench
=================================

DOT_PRODUCT_MC -- requirements
Module: dot_product_mc

Interface
REQ-001 SHALL have parameter PIXEL_N, default 785: pixels per frame.
REQ-002 SHALL have parameter PIXEL_SIZE, default 10: unsigned integer pixel width.
REQ-003 SHALL have parameter WEIGHT_SIZE, default 19: signed two's-complement weight, 18 fraction bits.
REQ-004 SHALL have parameter VAL_SIZE, default 26: signed result, 8 integer bits (incl. sign), 18 fraction bits.
REQ-005 SHALL have parameter PARALLEL, default 4: pixel lanes per beat.
REQ-006 SHALL have parameter NEURONS, default 2: independent weight channels sharing one pixel stream.
REQ-007 SHALL have port clk  input  1: single clock, rising edge.
REQ-008 SHALL have port GlobalReset  input  1: asynchronous, active-high reset.
REQ-009 SHALL have port in_valid  input  1: input beat valid.
REQ-010 SHALL have port in_ready  output  1: block accepts beat.
REQ-011 SHALL have port Pixels  input  PARALLEL*PIXEL_SIZE: lane j at [j*PIXEL_SIZE +: PIXEL_SIZE].
REQ-012 SHALL have port Weights  input  NEURONS*PARALLEL*WEIGHT_SIZE: neuron n, lane j at [(n*PARALLEL+j)*WEIGHT_SIZE +: WEIGHT_SIZE].
REQ-013 SHALL have port Bias  input  NEURONS*VAL_SIZE: per-neuron bias, same format as result.
REQ-014 SHALL have port relu_en  input  1: clamp negative results to zero.
REQ-015 SHALL have port out_valid  output  1: results valid.
REQ-016 SHALL have port out_ready  input  1: consumer accepts results.
REQ-017 SHALL have port value  output  NEURONS*VAL_SIZE: neuron n at [n*VAL_SIZE +: VAL_SIZE].
REQ-018 SHALL have port ovf  output  NEURONS: per-neuron saturation flag, valid with out_valid.

Function
REQ-019 SHALL accept a beat on any rising edge with in_valid=1 and in_ready=1; bubbles (in_valid=0) SHALL not alter accumulation.
REQ-020 SHALL define BEATS = ceil(PIXEL_N/PARALLEL); global pixel index of lane j in beat b = b*PARALLEL+j.
REQ-021 SHALL zero the product of any lane whose global index >= PIXEL_N, regardless of input data.
REQ-022 SHALL use states IDLE, ACCUM, DRAIN, OUT; IDLE->ACCUM on first accepted beat; ACCUM->DRAIN on acceptance of beat BEATS-1; DRAIN->OUT after pipeline empties; OUT->IDLE on out_valid & out_ready.
REQ-023 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in DRAIN and OUT.
REQ-024 SHALL sample Bias and relu_en on the first accepted beat of a frame and hold them for that frame.
REQ-025 SHALL pipeline: stage 1 registered products, stage 2 registered lane-sum tree, stage 3 accumulator, stage 4 registered bias/saturate/ReLU result.
REQ-026 SHALL assert out_valid on the 4th rising edge after the edge accepting the last beat.
REQ-027 SHALL keep the accumulator at full precision (no truncation) with at least clog2(PIXEL_N) guard bits above the product width.
REQ-028 SHALL compute acc+bias, then saturate to VAL_SIZE signed: above max -> 2^(VAL_SIZE-1)-1, below min -> -2^(VAL_SIZE-1); ovf[n]=1 iff clipped.
REQ-029 SHALL, when relu_en sampled 1, output 0 for any negative saturated result (ovf unchanged).
REQ-030 SHALL hold value, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-031 SHALL clear accumulators and beat counter on leaving OUT so the next frame starts from zero.
REQ-032 SHALL handle PARALLEL not dividing PIXEL_N and PIXEL_N < PARALLEL (BEATS=1) correctly.

Reset
REQ-033 SHALL, on GlobalReset=1, immediately force state IDLE, in_ready=0, out_valid=0, value=0, ovf=0, accumulators, pipeline registers and beat counter to 0, including mid-frame.
REQ-034 SHALL drive in_ready=1 on the first rising edge after GlobalReset deasserts.

Verification
REQ-035 SHALL test: defaults, pixel i = i%3, all weights 19'h08000 (0.125), Bias 0, relu_en 0, 197 beats (last beat lanes 1-3 random) -> value per neuron 26'h1880000 (98.0), ovf 0, out_valid 4 cycles after last beat.
REQ-036 SHALL test: same frame, Bias 26'h0080000 (2.0) -> 26'h1900000 (100.0).
REQ-037 SHALL test: neuron 0 weights 19'h78000 (-0.125), relu_en 0 -> 26'h2780000 (-98.0); relu_en 1 -> 0; neuron 1 unaffected (98.0).
REQ-038 SHALL test: all pixels 1023, weights 19'h3FFFF -> value 26'h1FFFFFF, ovf 1; weights 19'h40000 -> 26'h2000000, ovf 1.
REQ-039 SHALL test: random in_valid bubbles and out_ready low for 10 cycles -> result identical to REQ-035, value stable, in_ready 0 throughout OUT.
REQ-040 SHALL test: GlobalReset asserted after 50 beats -> all outputs 0 immediately; following full frame returns 26'h1880000 with no residue.

Source files
------------

// File: rtl/dot_product_mc.sv
// Multi-neuron dot product engine.
// One unsigned pixel stream is multiplied lane-by-lane against NEURONS signed
// weight streams and accumulated over a frame. A per-neuron bias is then added,
// the sum saturates to the result format, and an optional ReLU is applied.
// Pipeline: products -> lane-sum tree -> accumulator -> bias/saturate/ReLU.
module dot_product_mc #(
    parameter int PIXEL_N     = 785,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int PARALLEL    = 4,
    parameter int NEURONS     = 2
) (
    input  logic                                   clk,
    input  logic                                   GlobalReset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [PARALLEL*PIXEL_SIZE-1:0]         Pixels,
    input  logic [NEURONS*PARALLEL*WEIGHT_SIZE-1:0] Weights,
    input  logic [NEURONS*VAL_SIZE-1:0]            Bias,
    input  logic                                   relu_en,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NEURONS*VAL_SIZE-1:0]            value,
    output logic [NEURONS-1:0]                     ovf
);

    localparam int BEATS  = (PIXEL_N + PARALLEL - 1) / PARALLEL;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Unsigned pixel is widened by one zero bit so the product is a plain signed multiply.
    localparam int PROD_W = PIXEL_SIZE + WEIGHT_SIZE + 1;
    localparam int SUM_W  = PROD_W + $clog2(PARALLEL) + 1;
    localparam int ACC_W  = PROD_W + $clog2(PIXEL_N) + 1;
    localparam int RES_W  = ACC_W + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic signed [RES_W-1:0] SAT_MAX = {{(RES_W-VAL_SIZE+1){1'b0}}, {(VAL_SIZE-1){1'b1}}};
    localparam logic signed [RES_W-1:0] SAT_MIN = {{(RES_W-VAL_SIZE+1){1'b1}}, {(VAL_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Clamp a wide signed sum into the result format; MSB of the return is the clip flag.
    function automatic logic [VAL_SIZE:0] saturate(input logic signed [RES_W-1:0] x);
        logic [VAL_SIZE:0] r;
        if (x > SAT_MAX) begin
            r = {1'b1, 1'b0, {(VAL_SIZE-1){1'b1}}};
        end else if (x < SAT_MIN) begin
            r = {1'b1, 1'b1, {(VAL_SIZE-1){1'b0}}};
        end else begin
            r = {1'b0, x[VAL_SIZE-1:0]};
        end
        return r;
    endfunction

    state_t state_r, state_nxt_s;

    logic                          in_ready_r, in_ready_nxt_s;
    logic                          out_valid_r, out_valid_nxt_s;
    logic                          accept_s, last_beat_s, first_beat_s;
    logic                          load_res_s, clr_frame_s;
    logic [CNT_W-1:0]              beat_cnt_r;
    logic [1:0]                    drain_cnt_r;
    logic [PARALLEL-1:0]           lane_mask_s;

    logic signed [PROD_W-1:0]      pix_ext_s [PARALLEL];
    logic signed [PROD_W-1:0]      w_ext_s   [NEURONS][PARALLEL];
    logic signed [PROD_W-1:0]      prod_s    [NEURONS][PARALLEL];
    logic signed [PROD_W-1:0]      prod_r    [NEURONS][PARALLEL];
    logic                          p1_vld_r, p2_vld_r;
    logic signed [SUM_W-1:0]       sum_s [NEURONS];
    logic signed [SUM_W-1:0]       sum_r [NEURONS];
    logic signed [ACC_W-1:0]       acc_r [NEURONS];
    logic signed [VAL_SIZE-1:0]    bias_r [NEURONS];
    logic                          relu_r;

    logic signed [RES_W-1:0]       tot_s [NEURONS];
    logic [VAL_SIZE:0]             sat_s [NEURONS];
    logic [VAL_SIZE-1:0]           res_s [NEURONS];
    logic [NEURONS*VAL_SIZE-1:0]   value_r;
    logic [NEURONS-1:0]            ovf_r;

    assign accept_s     = in_valid && in_ready_r;
    assign last_beat_s  = (beat_cnt_r == LAST_BEAT);
    assign first_beat_s = accept_s && (state_r == ST_IDLE);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign value     = value_r;
    assign ovf       = ovf_r;

    // State register
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a single-beat frame goes straight from IDLE to DRAIN
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = last_beat_s ? ST_DRAIN : ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && last_beat_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 2'd3) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs can be registered
    always_comb begin
        in_ready_nxt_s  = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACCUM);
        out_valid_nxt_s = (state_nxt_s == ST_OUT);
        load_res_s      = (state_r == ST_DRAIN) && (state_nxt_s == ST_OUT);
        clr_frame_s     = (state_r == ST_OUT) && (state_nxt_s == ST_IDLE);
    end

    // Handshake outputs, beat/drain counters and per-frame bias/ReLU capture
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            beat_cnt_r  <= {CNT_W{1'b0}};
            drain_cnt_r <= 2'd0;
            relu_r      <= 1'b0;
            for (int n = 0; n < NEURONS; n++) begin
                bias_r[n] <= {VAL_SIZE{1'b0}};
            end
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            if (clr_frame_s) begin
                beat_cnt_r <= {CNT_W{1'b0}};
            end else if (accept_s) begin
                beat_cnt_r <= last_beat_s ? {CNT_W{1'b0}} : beat_cnt_r + CNT_W'(1'b1);
            end
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + 2'd1 : 2'd0;
            if (first_beat_s) begin
                relu_r <= relu_en;
                for (int n = 0; n < NEURONS; n++) begin
                    bias_r[n] <= Bias[n*VAL_SIZE +: VAL_SIZE];
                end
            end
        end
    end

    // Lanes past the end of the frame contribute nothing, whatever data they carry
    always_comb begin
        lane_mask_s = {PARALLEL{1'b0}};
        for (int j = 0; j < PARALLEL; j++) begin
            lane_mask_s[j] = ((int'(beat_cnt_r) * PARALLEL + j) < PIXEL_N);
        end
    end

    // Operand widening and masked products for every neuron/lane pair
    always_comb begin
        for (int j = 0; j < PARALLEL; j++) begin
            pix_ext_s[j] = PROD_W'(Pixels[j*PIXEL_SIZE +: PIXEL_SIZE]);
        end
        for (int n = 0; n < NEURONS; n++) begin
            for (int j = 0; j < PARALLEL; j++) begin
                w_ext_s[n][j] = PROD_W'($signed(Weights[(n*PARALLEL+j)*WEIGHT_SIZE +: WEIGHT_SIZE]));
                if (lane_mask_s[j]) begin
                    prod_s[n][j] = pix_ext_s[j] * w_ext_s[n][j];
                end else begin
                    prod_s[n][j] = {PROD_W{1'b0}};
                end
            end
        end
    end

    // Lane-sum tree over the registered products
    always_comb begin
        for (int n = 0; n < NEURONS; n++) begin
            sum_s[n] = {SUM_W{1'b0}};
            for (int j = 0; j < PARALLEL; j++) begin
                sum_s[n] = sum_s[n] + SUM_W'(prod_r[n][j]);
            end
        end
    end

    // Product, lane-sum and accumulator stages; accumulators clear when the result is taken
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            p1_vld_r <= 1'b0;
            p2_vld_r <= 1'b0;
            for (int n = 0; n < NEURONS; n++) begin
                sum_r[n] <= {SUM_W{1'b0}};
                acc_r[n] <= {ACC_W{1'b0}};
                for (int j = 0; j < PARALLEL; j++) begin
                    prod_r[n][j] <= {PROD_W{1'b0}};
                end
            end
        end else begin
            p1_vld_r <= accept_s;
            p2_vld_r <= p1_vld_r;
            for (int n = 0; n < NEURONS; n++) begin
                if (accept_s) begin
                    for (int j = 0; j < PARALLEL; j++) begin
                        prod_r[n][j] <= prod_s[n][j];
                    end
                end
                if (p1_vld_r) begin
                    sum_r[n] <= sum_s[n];
                end
                if (clr_frame_s) begin
                    acc_r[n] <= {ACC_W{1'b0}};
                end else if (p2_vld_r) begin
                    acc_r[n] <= acc_r[n] + ACC_W'(sum_r[n]);
                end
            end
        end
    end

    // Bias add, saturation and optional ReLU on the final accumulator value
    always_comb begin
        for (int n = 0; n < NEURONS; n++) begin
            tot_s[n] = RES_W'(acc_r[n]) + RES_W'(bias_r[n]);
            sat_s[n] = saturate(tot_s[n]);
            if (relu_r && sat_s[n][VAL_SIZE-1]) begin
                res_s[n] = {VAL_SIZE{1'b0}};
            end else begin
                res_s[n] = sat_s[n][VAL_SIZE-1:0];
            end
        end
    end

    // Result stage: captured once as the pipeline drains, held through OUT
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            value_r <= {(NEURONS*VAL_SIZE){1'b0}};
            ovf_r   <= {NEURONS{1'b0}};
        end else if (load_res_s) begin
            for (int n = 0; n < NEURONS; n++) begin
                value_r[n*VAL_SIZE +: VAL_SIZE] <= res_s[n];
                ovf_r[n]                        <= sat_s[n][VAL_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_dot_product_mc.sv
// Self-checking bench for dot_product_mc: frame data lives in plain arrays,
// a behavioural model sums pixel*weight with 64-bit integers, adds bias,
// clamps and applies ReLU; one compare process checks every output cycle.
module tb_dot_product_mc;

    localparam int PIXEL_N     = 785;
    localparam int PIXEL_SIZE  = 10;
    localparam int WEIGHT_SIZE = 19;
    localparam int VAL_SIZE    = 26;
    localparam int PARALLEL    = 4;
    localparam int NEURONS     = 2;
    localparam int BEATS       = (PIXEL_N + PARALLEL - 1) / PARALLEL;
    localparam int FR          = BEATS * PARALLEL;
    localparam longint MAXV    = (longint'(1) << (VAL_SIZE - 1)) - 1;
    localparam longint MINV    = -(longint'(1) << (VAL_SIZE - 1));

    logic clk = 1'b0;
    logic GlobalReset;
    logic in_valid, in_ready, relu_en, out_valid, out_ready;
    logic [PARALLEL*PIXEL_SIZE-1:0]          Pixels;
    logic [NEURONS*PARALLEL*WEIGHT_SIZE-1:0] Weights;
    logic [NEURONS*VAL_SIZE-1:0]             Bias;
    logic [NEURONS*VAL_SIZE-1:0]             value;
    logic [NEURONS-1:0]                      ovf;

    dot_product_mc #(
        .PIXEL_N(PIXEL_N), .PIXEL_SIZE(PIXEL_SIZE), .WEIGHT_SIZE(WEIGHT_SIZE),
        .VAL_SIZE(VAL_SIZE), .PARALLEL(PARALLEL), .NEURONS(NEURONS)
    ) dut (
        .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
        .Pixels(Pixels), .Weights(Weights), .Bias(Bias), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .value(value), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int     pix_a [FR];
    int     w_a   [NEURONS][FR];
    int     bias_a[NEURONS];
    bit     relu_f;
    longint exp_val[NEURONS];
    bit     exp_ovf[NEURONS];
    bit     exp_active = 1'b0;
    int     done_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int rnd_w();
        int v;
        v = int'($urandom_range(0, (1 << WEIGHT_SIZE) - 1));
        return (v >= (1 << (WEIGHT_SIZE - 1))) ? v - (1 << WEIGHT_SIZE) : v;
    endfunction

    // Reference: dot product over real pixels only, plus bias, clamp, ReLU.
    function automatic void model();
        longint acc;
        for (int n = 0; n < NEURONS; n++) begin
            acc = 0;
            for (int i = 0; i < PIXEL_N; i++) acc += longint'(pix_a[i]) * longint'(w_a[n][i]);
            acc += longint'(bias_a[n]);
            if (acc > MAXV) begin exp_val[n] = MAXV; exp_ovf[n] = 1'b1; end
            else if (acc < MINV) begin exp_val[n] = MINV; exp_ovf[n] = 1'b1; end
            else begin exp_val[n] = acc; exp_ovf[n] = 1'b0; end
            if (relu_f && exp_val[n] < 0) exp_val[n] = 0;
        end
    endfunction

    // Pixel i = i%3, weights 0.125; padding lanes of the last beat get random data.
    function automatic void setup_base(input int bias, input bit relu);
        for (int i = 0; i < FR; i++) begin
            pix_a[i] = (i < PIXEL_N) ? i % 3 : int'($urandom_range(0, 1023));
            for (int n = 0; n < NEURONS; n++) w_a[n][i] = (i < PIXEL_N) ? 32768 : rnd_w();
        end
        for (int n = 0; n < NEURONS; n++) bias_a[n] = bias;
        relu_f = relu;
    endfunction

    function automatic void setup_const(input int pix, input int w);
        for (int i = 0; i < FR; i++) begin
            pix_a[i] = pix;
            for (int n = 0; n < NEURONS; n++) w_a[n][i] = w;
        end
        for (int n = 0; n < NEURONS; n++) bias_a[n] = 0;
        relu_f = 1'b0;
    endfunction

    function automatic void setup_random();
        int span;
        span = int'($urandom_range(50, 600));
        for (int i = 0; i < FR; i++) begin
            pix_a[i] = int'($urandom_range(0, 1023));
            for (int n = 0; n < NEURONS; n++) w_a[n][i] = int'($urandom_range(0, 2 * span)) - span;
        end
        for (int n = 0; n < NEURONS; n++)
            bias_a[n] = int'($urandom_range(0, (1 << VAL_SIZE) - 1)) - (1 << (VAL_SIZE - 1));
        relu_f = 1'($urandom);
    endfunction

    // Bias/relu_en carry frame values only on beat 0; later beats carry noise the DUT must ignore.
    task automatic drive_lanes(input int b, input bit junk);
        int idx;
        for (int j = 0; j < PARALLEL; j++) begin
            idx = b * PARALLEL + j;
            Pixels[j*PIXEL_SIZE +: PIXEL_SIZE] = junk ? PIXEL_SIZE'($urandom) : PIXEL_SIZE'(pix_a[idx]);
            for (int n = 0; n < NEURONS; n++)
                Weights[(n*PARALLEL+j)*WEIGHT_SIZE +: WEIGHT_SIZE] =
                    junk ? WEIGHT_SIZE'($urandom) : WEIGHT_SIZE'(w_a[n][idx]);
        end
        for (int n = 0; n < NEURONS; n++)
            Bias[n*VAL_SIZE +: VAL_SIZE] = (b == 0 && !junk) ? VAL_SIZE'(bias_a[n]) : VAL_SIZE'($urandom);
        relu_en = (b == 0 && !junk) ? relu_f : 1'($urandom);
    endtask

    // Stream one frame (bub = bubble percentage, stall = cycles out_ready held low,
    // abort > 0 stops after that many beats without waiting for a result).
    task automatic send_frame(input int bub, input int stall, input int abort);
        int b, k, start_done, nbeats;
        model();
        exp_active = 1'b1;
        start_done = done_cnt;
        out_ready  = (stall == 0);
        nbeats     = (abort > 0) ? abort : BEATS;
        b = 0;
        while (b < nbeats) begin
            if (bub > 0 && int'($urandom_range(0, 99)) < bub) begin
                in_valid = 1'b0;
                drive_lanes(b, 1'b1);
                @(posedge clk); #1;
            end else begin
                in_valid = 1'b1;
                drive_lanes(b, 1'b0);
                k = 0;
                while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
                if (!in_ready) begin
                    check("in_ready_wait", in_ready, 1);
                    in_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
                b++;
            end
        end
        in_valid = 1'b0;
        drive_lanes(0, 1'b1);
        if (abort > 0) return;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!out_valid && k < 20);
        check("out_valid_latency", k, 4);
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        k = 0;
        while (done_cnt == start_done && k < 50) begin @(posedge clk); #1; k++; end
        check("result_handshake", done_cnt - start_done, 1);
    endtask

    // Compare process: every output-valid cycle against the model, plus hold-while-stalled.
    logic [NEURONS*VAL_SIZE-1:0] prev_value;
    logic [NEURONS-1:0]          prev_ovf;
    bit                          prev_hold = 1'b0;
    always @(negedge clk) begin
        if (GlobalReset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_out_valid", out_valid, 1);
                check("hold_value", value == prev_value, 1);
                check("hold_ovf", ovf == prev_ovf, 1);
            end
            if (out_valid) begin
                check("out_valid_expected", exp_active, 1);
                for (int n = 0; n < NEURONS; n++) begin
                    check($sformatf("value[%0d]", n), $signed(value[n*VAL_SIZE +: VAL_SIZE]), exp_val[n]);
                    check($sformatf("ovf[%0d]", n), ovf[n], exp_ovf[n]);
                end
                check("in_ready_in_out", in_ready, 0);
                if (out_ready) begin
                    done_cnt++;
                    exp_active = 1'b0;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_value = value;
            prev_ovf   = ovf;
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        GlobalReset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        Pixels = '0; Weights = '0; Bias = '0; relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_value", value, 0);
        check("rst_ovf", ovf, 0);
        GlobalReset = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1);

        // Base frame: 98.0 on both neurons
        setup_base(0, 1'b0); model();
        check("pin_base_n0", exp_val[0], 64'h1880000);
        check("pin_base_n1", exp_val[1], 64'h1880000);
        send_frame(0, 0, 0);

        // Bias 2.0 -> 100.0
        setup_base(32'h0080000, 1'b0); model();
        check("pin_bias", exp_val[0], 64'h1900000);
        send_frame(0, 0, 0);

        // Neuron 0 negative weights, ReLU off then on
        setup_base(0, 1'b0);
        for (int i = 0; i < PIXEL_N; i++) w_a[0][i] = -32768;
        model();
        check("pin_neg_n0", exp_val[0] & 64'h3FFFFFF, 64'h2780000);
        check("pin_neg_n1", exp_val[1], 64'h1880000);
        send_frame(0, 0, 0);
        relu_f = 1'b1; model();
        check("pin_relu_n0", exp_val[0], 0);
        send_frame(0, 0, 0);

        // Saturation both directions
        setup_const(1023, 32'h3FFFF); model();
        check("pin_sat_hi", exp_val[0] & 64'h3FFFFFF, 64'h1FFFFFF);
        check("pin_sat_hi_ovf", exp_ovf[0], 1);
        send_frame(0, 0, 0);
        setup_const(1023, -32'h40000); model();
        check("pin_sat_lo", exp_val[0] & 64'h3FFFFFF, 64'h2000000);
        send_frame(0, 0, 0);

        // Bubbles and a 10-cycle consumer stall
        setup_base(0, 1'b0);
        send_frame(30, 10, 0);

        // Reset in the middle of a frame, then a clean frame
        setup_base(0, 1'b0);
        send_frame(0, 0, 50);
        exp_active = 1'b0;
        GlobalReset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_value", value, 0);
        check("mid_rst_ovf", ovf, 0);
        @(posedge clk); #1;
        GlobalReset = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_mid_rst", in_ready, 1);
        setup_base(0, 1'b0);
        send_frame(0, 0, 0);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            setup_random();
            send_frame(20, int'($urandom_range(0, 5)), 0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
